// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one request at a time to a
// wait-stated instruction memory and holds the fetched word until decode takes it.
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a cycle with mem_req=1 and mem_gnt=1,
  // and the held instruction transfers on a cycle with if_valid=1 and if_ready=1.
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] jump_tgt;
  logic        unused_jump_lsbs;

  assign jump_tgt         = {jump_addr[31:2], 2'b00};
  assign unused_jump_lsbs = ^jump_addr[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      ST_REQ: begin
        if (jump_flag) begin
          pc_d = jump_tgt;
          if (mem_gnt) begin
            // The old address was already accepted; its response must be dropped.
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          if (kill_q || jump_flag) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
            if (jump_flag) pc_d = jump_tgt;
          end else begin
            if_instr_d = mem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            state_d    = ST_HOLD;
          end
        end else if (jump_flag) begin
          pc_d   = jump_tgt;
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (jump_flag) begin
          if_valid_d = 1'b0;
          pc_d       = jump_tgt;
          state_d    = ST_REQ;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          pc_d       = pc_q + 32'd4;
          state_d    = ST_REQ;
        end
      end
      default: begin
        state_d    = ST_REQ;
        kill_d     = 1'b0;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      pc_q       <= PC_RESET_ADDR;
      kill_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_instr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign mem_req   = (state_q == ST_REQ);
  assign mem_addr  = pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run checked against
// a program-order model (next PC advances by 4 on accept, jumps to target on redirect).
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // memory responder controls
  int          gnt_dly   = 0;
  int          rv_dly    = 1;
  bit          rand_mode = 0;
  bit          use_const = 0;
  bit          resp_pending;
  int          resp_cnt;
  int          req_cnt;
  logic [31:0] resp_addr;

  fetch_ctrl #(.PC_RESET_ADDR(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jump_flag  (jump_flag),
    .jump_addr  (jump_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .if_ready   (if_ready),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (use_const) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  // Instruction memory: drives its inputs 2ns after each rising edge.
  initial begin
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = 32'd0;
    resp_pending = 1'b0;
    resp_cnt     = 0;
    req_cnt      = 0;
    resp_addr    = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (!rst_n) begin
        resp_pending = 1'b0;
        req_cnt      = 0;
      end else if (resp_pending) begin
        resp_cnt = resp_cnt - 1;
        if (resp_cnt == 0) begin
          mem_rvalid   = 1'b1;
          mem_rdata    = word_of(resp_addr);
          resp_pending = 1'b0;
        end
      end else if (mem_req) begin
        if (req_cnt >= gnt_dly) begin
          mem_gnt      = 1'b1;
          resp_pending = 1'b1;
          resp_addr    = mem_addr;
          resp_cnt     = rv_dly;
          req_cnt      = 0;
          if (rand_mode) begin
            gnt_dly = $urandom_range(0, 3);
            rv_dly  = $urandom_range(1, 3);
          end
        end else begin
          req_cnt = req_cnt + 1;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    jump_flag = 1'b0;
    jump_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    gnt_dly = 0; rv_dly = 1; rand_mode = 0; use_const = 1; if_ready = 1'b0;
    do_reset();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_mem_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== RST_PC) begin bad++; $display("FAIL rst_mem_addr got=%h exp=%h", mem_addr, RST_PC); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    total++; if (if_pc !== 32'd0) begin bad++; $display("FAIL rst_if_pc got=%h exp=0", if_pc); end
    total++; if (if_instr !== 32'd0) begin bad++; $display("FAIL rst_if_instr got=%h exp=0", if_instr); end
  endtask

  task automatic test_basic();
    if_ready = 1'b1;
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL basic_wait_req got=%b exp=0", mem_req); end
    tick();
    total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", if_valid); end
    total++; if (if_pc !== 32'h100) begin bad++; $display("FAIL basic_if_pc got=%h exp=100", if_pc); end
    total++; if (if_instr !== 32'h13) begin bad++; $display("FAIL basic_if_instr got=%h exp=13", if_instr); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin bad++; $display("FAIL basic_addr2 got=%b/%h exp=1/104", mem_req, mem_addr); end
    repeat (3) tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin bad++; $display("FAIL basic_addr3 got=%b/%h exp=1/108", mem_req, mem_addr); end
    use_const = 0;
  endtask

  task automatic test_wait_states();
    int pulses;
    bit prev_v;
    gnt_dly = 3; rv_dly = 2; if_ready = 1'b1;
    do_reset();
    pulses = 0;
    prev_v = 1'b0;
    for (int c = 0; c < 28; c++) begin
      if (c < 4) begin
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
          bad++; $display("FAIL ws_req_stable c=%0d got=%b/%h exp=1/100", c, mem_req, mem_addr);
        end
      end
      if (if_valid === 1'b1) begin
        total++;
        if (prev_v) begin bad++; $display("FAIL ws_pulse_width c=%0d got=2+ exp=1", c); end
        total++;
        if (if_pc !== RST_PC + 32'(4 * pulses)) begin
          bad++; $display("FAIL ws_if_pc got=%h exp=%h", if_pc, RST_PC + 32'(4 * pulses));
        end
        pulses++;
      end
      prev_v = if_valid;
      tick();
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL ws_pulse_count got=%0d exp=4", pulses); end
  endtask

  task automatic test_hold();
    logic [31:0] pc0, in0;
    gnt_dly = 0; rv_dly = 1; if_ready = 1'b0;
    do_reset();
    repeat (2) tick();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin bad++; $display("FAIL hold_first got=%b/%h exp=1/100", if_valid, if_pc); end
    total++; if (if_instr !== word_of(32'h100)) begin bad++; $display("FAIL hold_instr got=%h exp=%h", if_instr, word_of(32'h100)); end
    pc0 = if_pc;
    in0 = if_instr;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (if_valid !== 1'b1 || if_pc !== pc0 || if_instr !== in0 || mem_req !== 1'b0) begin
        bad++; $display("FAIL hold_stable c=%0d got=%b/%h/%h/%b", c, if_valid, if_pc, if_instr, mem_req);
      end
    end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || if_valid !== 1'b0) begin
      bad++; $display("FAIL hold_advance got=%b/%h/%b exp=1/104/0", mem_req, mem_addr, if_valid);
    end
  endtask

  task automatic test_jump_wait();
    bit found;
    bit seen_req;
    gnt_dly = 0; rv_dly = 3; if_ready = 1'b1;
    do_reset();
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_req === 1'b1 && mem_addr === 32'h104) found = 1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL jw_reach_104 got=timeout exp=req 104"); end
    tick();
    if_ready  = 1'b0;
    jump_flag = 1'b1;
    jump_addr = 32'h200;
    tick();
    jump_flag = 1'b0;
    found = 0;
    seen_req = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (mem_req === 1'b1 && !seen_req) begin
        seen_req = 1;
        total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL jw_redirect_addr got=%h exp=200", mem_addr); end
      end
      if (if_valid === 1'b1) begin
        found = 1;
        total++; if (!seen_req || if_pc !== 32'h200) begin bad++; $display("FAIL jw_if_pc got=%h exp=200", if_pc); end
        total++; if (if_instr !== word_of(32'h200)) begin bad++; $display("FAIL jw_if_instr got=%h exp=%h", if_instr, word_of(32'h200)); end
      end else begin
        tick();
      end
    end
    total++; if (!found) begin bad++; $display("FAIL jw_valid got=timeout exp=if_valid"); end
  endtask

  task automatic test_jump_hold();
    bit found;
    jump_flag = 1'b1;
    jump_addr = 32'h300;
    if_ready  = 1'b1;
    tick();
    jump_flag = 1'b0;
    if_ready  = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || if_valid !== 1'b0) begin
      bad++; $display("FAIL jh_priority got=%b/%h/%b exp=1/300/0", mem_req, mem_addr, if_valid);
    end
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (if_valid === 1'b1) found = 1;
      else tick();
    end
    total++; if (!found || if_pc !== 32'h300) begin bad++; $display("FAIL jh_if_pc got=%b/%h exp=1/300", found, if_pc); end
    jump_flag = 1'b1;
    jump_addr = 32'h302;
    tick();
    jump_flag = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("FAIL jh_lsb_mask got=%b/%h exp=1/300", mem_req, mem_addr); end
  endtask

  task automatic test_wrap_reset();
    bit found;
    jump_flag = 1'b1;
    jump_addr = 32'hFFFF_FFFC;
    tick();
    jump_flag = 1'b0;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (if_valid === 1'b1 && if_pc === 32'hFFFF_FFFC) found = 1;
      else tick();
    end
    total++; if (!found) begin bad++; $display("FAIL wrap_hold got=%b/%h exp=1/fffffffc", if_valid, if_pc); end
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%b/%h exp=1/0", mem_req, mem_addr); end
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wrap_in_wait got=%b exp=0", mem_req); end
    rst_n = 1'b0;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin bad++; $display("FAIL midrst_req got=%b/%h exp=1/%h", mem_req, mem_addr, RST_PC); end
    total++; if (if_valid !== 1'b0 || if_pc !== 32'd0 || if_instr !== 32'd0) begin
      bad++; $display("FAIL midrst_if got=%b/%h/%h exp=0/0/0", if_valid, if_pc, if_instr);
    end
    tick();
    rst_n = 1'b1;
  endtask

  // Randomized run: model tracks only the address of the next instruction in program order.
  task automatic test_random();
    logic [31:0] model_pc;
    int          accepted;
    rand_mode = 1; gnt_dly = 1; rv_dly = 2; if_ready = 1'b0;
    do_reset();
    model_pc = RST_PC;
    accepted = 0;
    for (int c = 0; c < 2000; c++) begin
      if (mem_req === 1'b1) begin
        total++; if (mem_addr !== model_pc) begin bad++; $display("FAIL rnd_mem_addr c=%0d got=%h exp=%h", c, mem_addr, model_pc); end
      end
      if (if_valid === 1'b1) begin
        total++; if (if_pc !== model_pc) begin bad++; $display("FAIL rnd_if_pc c=%0d got=%h exp=%h", c, if_pc, model_pc); end
        total++; if (if_instr !== word_of(model_pc)) begin bad++; $display("FAIL rnd_if_instr c=%0d got=%h exp=%h", c, if_instr, word_of(model_pc)); end
      end
      total++; if (mem_req === 1'b1 && if_valid === 1'b1) begin bad++; $display("FAIL rnd_req_in_hold c=%0d got=1 exp=0", c); end
      jump_flag = ($urandom_range(0, 11) == 0);
      jump_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      if_ready  = $urandom_range(0, 1);
      if (jump_flag) model_pc = {jump_addr[31:2], 2'b00};
      else if (if_valid && if_ready) begin
        model_pc = model_pc + 32'd4;
        accepted++;
      end
      tick();
    end
    jump_flag = 1'b0;
    if_ready  = 1'b0;
    total++; if (accepted < 50) begin bad++; $display("FAIL rnd_progress got=%0d exp>=50", accepted); end
  endtask

  initial begin
    rst_n     = 1'b0;
    jump_flag = 1'b0;
    jump_addr = 32'd0;
    if_ready  = 1'b0;
    test_reset();
    test_basic();
    test_wait_states();
    test_hold();
    test_jump_wait();
    test_jump_hold();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the RV32 core. It owns the program counter and drives a request/grant/response instruction-memory port that tolerates wait states. It holds each fetched instruction in an output register until decode accepts it. Jump redirects are applied at any point in a fetch, and a response already in flight for a stale address is discarded. It replaces the free-running PC+4 fetch path when the instruction memory is not single-cycle combinational.

## Interface
- PC_RESET_ADDR, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- jump_flag  in  1  redirect request from execute, sampled every cycle
- jump_addr  in  32  redirect target; bits [1:0] ignored, treated as 0
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  32  fetch address; valid while mem_req=1
- mem_gnt  in  1  memory accepted request this cycle (meaningful only when mem_req=1)
- mem_rvalid  in  1  response data valid; exactly one per granted request, at least 1 cycle after grant
- mem_rdata  in  32  instruction word, valid with mem_rvalid
- if_valid  out  1  instruction held for decode
- if_pc  out  32  address of held instruction
- if_instr  out  32  held instruction word
- if_ready  in  1  decode accepts held instruction this cycle

## Operation
- State register: pc[31:0]. FSM states: REQ, WAIT, HOLD. One-bit kill flag. Only one request is outstanding at a time.
- REQ:
  - mem_req=1, mem_addr=pc.
  - jump_flag=1 with mem_gnt=0: pc<=jump_addr, stay in REQ. The address may change while the request is ungranted.
  - jump_flag=1 with mem_gnt=1: pc<=jump_addr, kill<=1, go to WAIT. The granted old-address response will be discarded.
  - mem_gnt=1 with no jump: go to WAIT.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1 and (kill=1 or jump_flag=1): discard the data, kill<=0, go to REQ. If jump_flag=1, also pc<=jump_addr.
  - mem_rvalid=1, clean: if_instr<=mem_rdata, if_pc<=pc, if_valid<=1, go to HOLD.
  - jump_flag=1 without rvalid: pc<=jump_addr, kill<=1, stay in WAIT.
- HOLD:
  - if_valid=1. Outputs stay stable until handshake or jump.
  - jump_flag=1: if_valid<=0, pc<=jump_addr, go to REQ. A jump has priority over if_ready in the same cycle.
  - if_ready=1 without jump: if_valid<=0, pc<=pc+4, go to REQ.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. pc[1:0] is always 0.
- Reset (also applies mid-fetch):
  - state<=REQ, pc<=PC_RESET_ADDR, kill<=0, if_valid<=0, if_pc<=0, if_instr<=0.
  - Any in-flight response is the memory's responsibility and is reset alongside the core. A response arriving in REQ is ignored.
- mem_rvalid in REQ or HOLD is a protocol violation: ignored, no state change.

## Timing
- Reset values: mem_req=1 and mem_addr=PC_RESET_ADDR in the first cycle after rst_n rises; if_valid=0, if_pc=0, if_instr=0.
- Best-case latency: grant in cycle N, rvalid in cycle N+1, if_valid=1 in cycle N+2.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD with if_ready=1).
- A jump takes effect on the next edge. The redirect target appears on mem_addr at most 1 cycle after the stale response (or immediately if in REQ/HOLD).
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Test plan
1. Reset release with PC_RESET_ADDR=32'h100, and memory granting immediately with rvalid 1 cycle later and data 32'h00000013:
   - mem_addr=32'h100 in cycle 0, if_valid=1 with if_pc=32'h100 in cycle 2.
   - if_ready held at 1 gives mem_addr sequence 32'h104, 32'h108.
2. Grant delayed 3 cycles and rvalid delayed 2 cycles: mem_req stays 1 with a stable address until the grant, and exactly one if_valid pulse occurs per instruction.
3. if_ready=0 for 5 cycles in HOLD: if_valid, if_pc and if_instr are constant and mem_req=0. Raising if_ready for one cycle advances pc by 4.
4. jump_flag pulse to 32'h200 during WAIT (pc=32'h104): the response for 32'h104 is discarded with no if_valid, the next mem_addr is 32'h200, and the resulting if_pc is 32'h200.
5. jump_flag (target 32'h300) and if_ready both high in HOLD: the next fetch is 32'h300, not pc+4. A jump with jump_addr=32'h302 fetches 32'h300.
6. pc=32'hFFFF_FFFC accepted with if_ready: the next mem_addr is 32'h0. Asserting rst_n=0 during WAIT returns the block to its reset outputs on the next edge.
